// File: rtl/fp_addsub_arbiter.sv
// ============================================================================
// Module   : fp_addsub_arbiter
// Brief    : Round-robin arbiter feeding a shared combinational FP add/sub
//            unit through a two-stage (issue / response) pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_addsub_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [32*NREQ-1:0]   req_a_i,
  input  logic [32*NREQ-1:0]   req_b_i,
  input  logic [NREQ-1:0]      req_op_i,
  output logic [31:0]          fpu_a_o,
  output logic [31:0]          fpu_b_o,
  output logic                 fpu_op_o,
  input  logic [31:0]          fpu_z_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [1:0]           rsp_id_o,
  output logic [31:0]          rsp_z_o,
  output logic                 busy_o,
  output logic [15:0]          issued_count_o
);

  localparam int IDW = 2;

  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     fpu_a_q, fpu_a_d;
  logic [31:0]     fpu_b_q, fpu_b_d;
  logic            fpu_op_q, fpu_op_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_z_q, rsp_z_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     issued_q, issued_d;

  logic            adv1, adv2;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  cand;
  logic [31:0]     sel_a, sel_b;
  logic            sel_op;

  assign adv2 = !rsp_valid_q || rsp_ready_i;
  assign adv1 = !s1_valid_q || adv2;

  // Search ptr, ptr+1, ... with natural 2-bit wrap giving the modulo.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + IDW'(k);
      if (!gnt_vld && req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        sel_a  = req_a_i[32*k +: 32];
        sel_b  = req_b_i[32*k +: 32];
        sel_op = req_op_i[k];
      end
    end
  end

  assign req_ready_o = (adv1 && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_op_d    = fpu_op_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    issued_d    = issued_q;

    if (adv2) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_z_d  = fpu_z_i;
        rsp_id_d = s1_id_q;
      end
    end

    if (adv1) begin
      s1_valid_d = gnt_vld;
      if (gnt_vld) begin
        fpu_a_d  = sel_a;
        fpu_b_d  = sel_b;
        fpu_op_d = sel_op;
        s1_id_d  = gnt_idx;
        ptr_d    = gnt_idx + IDW'(1);
        issued_d = issued_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      issued_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
      issued_q    <= issued_d;
    end
  end

  assign fpu_a_o        = fpu_a_q;
  assign fpu_b_o        = fpu_b_q;
  assign fpu_op_o       = fpu_op_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_z_o        = rsp_z_q;
  assign rsp_id_o       = rsp_id_q;
  assign busy_o         = s1_valid_q || rsp_valid_q;
  assign issued_count_o = issued_q;

endmodule

`default_nettype wire
